frame_update_scheduler: RTL and testbench

//  Schedules game-state writes into the VGA display path so sprite state never changes mid-frame.
//  Two requesters share the displayed-state registers that feed pixel_Gen:
//   - physics (ball_x/ball_y)
//   - score logic (score)

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 39 +++
 rtl/frame_update_scheduler.sv | 142 ++++++++++++++
 tb/tb_frame_update_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, scheduler state encoding and requester indices
// for the frame update scheduler.
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam int V_TOTAL   = 525;

  localparam int PHYS  = 0;
  localparam int SCORE = 1;
  localparam int NREQ  = 2;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_WINDOW = 2'd1,
    ST_CLOSE  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves to
// the other requester whenever a grant is actually accepted.
module rr_arbiter2
  import vga_timing_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            accept_i,
  output logic [NREQ-1:0] gnt_o
);

  // ptr_q = 0 favours PHYS, 1 favours SCORE
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i[PHYS] && req_i[SCORE]) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && (gnt_o != '0)) begin
      ptr_d = gnt_o[PHYS];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/frame_update_scheduler.sv
// Gates physics and score writes into the displayed-state registers so they
// only change inside an update window at the start of vertical blanking.
module frame_update_scheduler
  import vga_timing_pkg::*;
#(
  parameter int V_DISPLAY    = vga_timing_pkg::V_DISPLAY,
  parameter int V_TOTAL      = vga_timing_pkg::V_TOTAL,
  parameter int UPDATE_LINES = 40,
  parameter int BALL_X_RST   = 320,
  parameter int BALL_Y_RST   = 400
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        p_tick,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        phys_req,
  input  logic [9:0]  phys_x,
  input  logic [9:0]  phys_y,
  output logic        phys_gnt,
  input  logic        score_req,
  input  logic [7:0]  score_val,
  output logic        score_gnt,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [7:0]  score,
  output logic        update_win,
  output logic        frame_tick,
  output logic [15:0] frame_count,
  output logic [1:0]  overrun
);

  if (V_DISPLAY + UPDATE_LINES >= V_TOTAL) begin : g_bad_cfg
    $error("update window must close before the end of the frame");
  end

  localparam logic [9:0] OPEN_LINE   = 10'(V_DISPLAY);
  localparam logic [9:0] CLOSE_LINE  = 10'(V_DISPLAY + UPDATE_LINES);
  localparam logic [9:0] BALL_X_INIT = 10'(BALL_X_RST);
  localparam logic [9:0] BALL_Y_INIT = 10'(BALL_Y_RST);

  sched_state_e    state_q, state_d;
  logic [NREQ-1:0] served_q, served_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            frame_tick_q, frame_tick_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [1:0]      overrun_q, overrun_d;
  logic [9:0]      ball_x_q, ball_x_d;
  logic [9:0]      ball_y_q, ball_y_d;
  logic [7:0]      score_q, score_d;

  logic [NREQ-1:0] req_vec;
  logic [NREQ-1:0] arb_gnt;
  logic            in_window;
  logic            open_ev;
  logic            close_ev;

  assign req_vec   = {score_req, phys_req};
  assign in_window = (state_q == ST_WINDOW);
  assign open_ev   = p_tick && (pixel_x == '0) && (pixel_y == OPEN_LINE);
  assign close_ev  = p_tick && (pixel_x == '0) && (pixel_y == CLOSE_LINE);

  rr_arbiter2 u_arb (
    .clk_i    (CLK100MHZ),
    .rst_i    (reset),
    .req_i    (req_vec & ~served_q),
    .accept_i (in_window),
    .gnt_o    (arb_gnt)
  );

  assign gnt_d = in_window ? arb_gnt : '0;

  always_comb begin
    state_d       = state_q;
    served_d      = served_q | gnt_d;
    frame_tick_d  = 1'b0;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    case (state_q)
      ST_ACTIVE: begin
        if (open_ev) begin
          state_d       = ST_WINDOW;
          frame_tick_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          served_d      = '0;
        end
      end
      ST_WINDOW: begin
        if (close_ev) begin
          state_d = ST_CLOSE;
        end
      end
      ST_CLOSE: begin
        state_d   = ST_ACTIVE;
        // anything still pending and unserved missed this window
        overrun_d = overrun_q | (req_vec & ~served_q);
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_comb begin
    ball_x_d = gnt_d[PHYS]  ? phys_x    : ball_x_q;
    ball_y_d = gnt_d[PHYS]  ? phys_y    : ball_y_q;
    score_d  = gnt_d[SCORE] ? score_val : score_q;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q       <= ST_ACTIVE;
      served_q      <= '0;
      gnt_q         <= '0;
      frame_tick_q  <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= '0;
      ball_x_q      <= BALL_X_INIT;
      ball_y_q      <= BALL_Y_INIT;
      score_q       <= '0;
    end else begin
      state_q       <= state_d;
      served_q      <= served_d;
      gnt_q         <= gnt_d;
      frame_tick_q  <= frame_tick_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      score_q       <= score_d;
    end
  end

  assign phys_gnt    = gnt_q[PHYS];
  assign score_gnt   = gnt_q[SCORE];
  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign score       = score_q;
  assign update_win  = in_window;
  assign frame_tick  = frame_tick_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed-plus-random bench for frame_update_scheduler using a compressed
// raster (4 pixels per line, pixel enable every other clock).
module tb_frame_update_scheduler;

  logic        clk;
  logic        rst;
  logic        p_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        phys_req;
  logic [9:0]  phys_x;
  logic [9:0]  phys_y;
  logic        phys_gnt;
  logic        score_req;
  logic [7:0]  score_val;
  logic        score_gnt;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [7:0]  score;
  logic        update_win;
  logic        frame_tick;
  logic [15:0] frame_count;
  logic [1:0]  overrun;

  int vectors;
  int miscompares;

  // reference model state
  logic [9:0]  m_bx;
  logic [9:0]  m_by;
  logic [7:0]  m_sc;
  logic [15:0] m_fc;
  logic [1:0]  m_ovr;
  logic [1:0]  m_srv;
  int          m_ptr;

  frame_update_scheduler dut (
    .CLK100MHZ   (clk),
    .reset       (rst),
    .p_tick      (p_tick),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .phys_req    (phys_req),
    .phys_x      (phys_x),
    .phys_y      (phys_y),
    .phys_gnt    (phys_gnt),
    .score_req   (score_req),
    .score_val   (score_val),
    .score_gnt   (score_gnt),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .score       (score),
    .update_win  (update_win),
    .frame_tick  (frame_tick),
    .frame_count (frame_count),
    .overrun     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // raster source: 4 columns x 525 lines, pixel enable on alternate clocks
  initial begin
    p_tick  = 1'b0;
    pixel_x = '0;
    pixel_y = '0;
    forever begin
      @(negedge clk);
      if (p_tick) begin
        if (pixel_x == 10'd3) begin
          pixel_x = '0;
          pixel_y = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
        end else begin
          pixel_x = pixel_x + 10'd1;
        end
      end
      p_tick = ~p_tick;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pix(input int y, input int x, input bit chk_ng);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
      if (chk_ng) chk("no_grant", 32'({phys_gnt, score_gnt}), 32'd0);
      hit = p_tick && (pixel_x == 10'(x)) && (pixel_y == 10'(y));
    end
    chk("reach_line", 32'(hit), 32'd1);
  endtask

  task automatic chk_display();
    chk("ball_x", 32'(ball_x), 32'(m_bx));
    chk("ball_y", 32'(ball_y), 32'(m_by));
    chk("score", 32'(score), 32'(m_sc));
  endtask

  task automatic open_frame();
    wait_pix(480, 0, 1'b1);
    m_fc  = m_fc + 16'd1;
    m_srv = 2'b00;
    chk("frame_tick", 32'(frame_tick), 32'd1);
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    chk("update_win_open", 32'(update_win), 32'd1);
    chk_display();
  endtask

  task automatic close_frame(input bit raise_s);
    wait_pix(520, 0, 1'b1);
    chk("update_win_close", 32'(update_win), 32'd0);
    if (raise_s) begin
      score_req = 1'b1;
      score_val = 8'($urandom);
    end
    m_ovr = m_ovr | ({score_req, phys_req} & ~m_srv);
    @(posedge clk);
    #1;
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk_display();
  endtask

  // expected order: lone requester first; both -> pointer favourite, then the other
  task automatic run_grants(input bit rp, input bit rs, input bit hold_p);
    int first;
    int second;
    bit ep;
    bit es;
    first  = -1;
    second = -1;
    if (rp && rs) begin
      first  = m_ptr;
      second = 1 - m_ptr;
    end else if (rp) begin
      first = 0;
    end else if (rs) begin
      first = 1;
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      ep = (k == 0 && first == 0) || (k == 1 && second == 0);
      es = (k == 0 && first == 1) || (k == 1 && second == 1);
      chk("phys_gnt", 32'(phys_gnt), 32'(ep));
      chk("score_gnt", 32'(score_gnt), 32'(es));
      if (ep) begin
        m_bx     = phys_x;
        m_by     = phys_y;
        m_ptr    = 1;
        m_srv[0] = 1'b1;
        if (!hold_p) phys_req = 1'b0;
      end
      if (es) begin
        m_sc      = score_val;
        m_ptr     = 0;
        m_srv[1]  = 1'b1;
        score_req = 1'b0;
      end
      chk_display();
    end
  endtask

  task automatic model_reset();
    m_bx  = 10'd320;
    m_by  = 10'd400;
    m_sc  = 8'd0;
    m_fc  = 16'd0;
    m_ovr = 2'b00;
    m_srv = 2'b00;
    m_ptr = 0;
  endtask

  initial begin
    bit rp;
    bit rs;
    int line;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    phys_req    = 1'b0;
    phys_x      = '0;
    phys_y      = '0;
    score_req   = 1'b0;
    score_val   = '0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_display();
    chk("rst_gnt", 32'({phys_gnt, score_gnt}), 32'd0);
    chk("rst_win", 32'(update_win), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;

    // first window: single-cycle tick, window spans lines 480..519
    open_frame();
    @(posedge clk);
    #1;
    chk("tick_one_cycle", 32'(frame_tick), 32'd0);
    wait_pix(519, 0, 1'b1);
    chk("win_line519", 32'(update_win), 32'd1);
    close_frame(1'b0);

    // physics request raised mid-frame waits for the window
    wait_pix(100, 0, 1'b1);
    phys_req = 1'b1;
    phys_x   = 10'($urandom_range(0, 639));
    phys_y   = 10'($urandom_range(0, 479));
    open_frame();
    run_grants(1'b1, 1'b0, 1'b0);
    close_frame(1'b0);

    // grant, then reset mid-window: write discarded, nothing until next open
    wait_pix(400, 0, 1'b1);
    phys_req = 1'b1;
    phys_x   = 10'($urandom_range(0, 639));
    phys_y   = 10'($urandom_range(0, 479));
    open_frame();
    run_grants(1'b1, 1'b0, 1'b1);
    wait_pix(490, 0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk("midrst_win", 32'(update_win), 32'd0);
    chk("midrst_count", 32'(frame_count), 32'd0);
    chk_display();
    rst = 1'b0;
    wait_pix(479, 0, 1'b1);
    score_req = 1'b1;
    score_val = 8'($urandom);
    open_frame();
    run_grants(1'b1, 1'b1, 1'b0);
    close_frame(1'b0);

    // both again on the following frame
    wait_pix(300, 0, 1'b1);
    phys_req  = 1'b1;
    phys_x    = 10'($urandom_range(0, 639));
    phys_y    = 10'($urandom_range(0, 479));
    score_req = 1'b1;
    score_val = 8'($urandom);
    open_frame();
    run_grants(1'b1, 1'b1, 1'b0);
    close_frame(1'b0);

    // physics held after its grant, score arrives as the window shuts
    wait_pix(300, 0, 1'b1);
    phys_req = 1'b1;
    phys_x   = 10'($urandom_range(0, 639));
    phys_y   = 10'($urandom_range(0, 479));
    open_frame();
    run_grants(1'b1, 1'b0, 1'b1);
    close_frame(1'b1);
    chk("overrun_score_only", 32'(overrun), 32'd2);
    phys_req  = 1'b0;
    score_req = 1'b0;

    // randomized frames
    for (int f = 0; f < 3; f++) begin
      line = int'($urandom_range(100, 470));
      rp   = 1'($urandom_range(0, 1));
      rs   = 1'($urandom_range(0, 1));
      wait_pix(line, 0, 1'b1);
      phys_req  = rp;
      phys_x    = 10'($urandom_range(0, 639));
      phys_y    = 10'($urandom_range(0, 479));
      score_req = rs;
      score_val = 8'($urandom);
      open_frame();
      run_grants(rp, rs, 1'b0);
      close_frame(1'b0);
    end

    // frame counter wrap
    wait_pix(200, 0, 1'b1);
    force dut.frame_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_count_q;
    m_fc = 16'hFFFF;
    open_frame();
    chk("wrap_zero", 32'(frame_count), 32'd0);
    close_frame(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
